// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - state and reset-cause codes shared by the reset sequencer
package rst_seq_pkg;

    localparam logic [1:0] HOLD    = 2'd0;
    localparam logic [1:0] STAGGER = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    // Watchdog outranks software when both requests arrive together.
    function automatic logic [1:0] req_cause(input logic wdt_req);
        return wdt_req ? CAUSE_WDT : CAUSE_SW;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - staggered per-domain reset release with sw/wdt restart
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOM    = 4,
    parameter int MIN_ASSERT = 8,
    parameter int REL_DLY    = 16,
    parameter int CNT_W      = $clog2((MIN_ASSERT > REL_DLY) ? MIN_ASSERT : REL_DLY) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_rst_req,
    input  logic               wdt_rst_req,
    output logic [NUM_DOM-1:0] dom_rst,
    output logic               all_released,
    output logic               busy,
    output logic [1:0]         rst_cause
);

    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(REL_DLY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

    generate
        if (NUM_DOM < 1 || NUM_DOM > 16 || MIN_ASSERT < 1 || REL_DLY < 1) begin : g_bad_param
            $error("rst_seq_ctrl: illegal NUM_DOM/MIN_ASSERT/REL_DLY");
        end
    endgenerate

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             req;

    assign req  = sw_rst_req | wdt_rst_req;
    assign busy = (state != DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HOLD;
            cnt          <= '0;
            idx          <= '0;
            dom_rst      <= '1;
            all_released <= 1'b0;
            rst_cause    <= CAUSE_POR;
        end else if (req) begin
            // A request pre-empts any release due on this same edge.
            state        <= HOLD;
            cnt          <= '0;
            idx          <= '0;
            dom_rst      <= '1;
            all_released <= 1'b0;
            rst_cause    <= req_cause(wdt_rst_req);
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= STAGGER;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STAGGER: begin
                    if (cnt == REL_LAST) begin
                        cnt     <= '0;
                        dom_rst <= dom_rst & ~(NUM_DOM'(1) << idx);
                        if (idx == IDX_LAST) begin
                            state        <= DONE;
                            all_released <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                end
                default: begin
                    // Unreachable encoding: restart the whole sequence.
                    state        <= HOLD;
                    cnt          <= '0;
                    idx          <= '0;
                    dom_rst      <= '1;
                    all_released <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb/tb_rst_seq_ctrl.sv - self-checking bench for rst_seq_ctrl
module tb_rst_seq_ctrl;

    localparam int ND  = 4;
    localparam int MIN = 8;
    localparam int REL = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sw_rst_req = 1'b0;
    logic          wdt_rst_req = 1'b0;
    logic [ND-1:0] dom_rst;
    logic          all_released;
    logic          busy;
    logic [1:0]    rst_cause;
    logic [0:0]    dom_rst_m;
    logic          all_released_m;
    logic          busy_m;
    logic [1:0]    rst_cause_m;

    int checks = 0;
    int errors = 0;
    int t = 0;
    logic [1:0] cause_exp = 2'b00;

    typedef struct {
        int            edge_n;
        logic [ND-1:0] dom;
        logic          all_rel;
        logic          bsy;
    } vec_t;

    vec_t por_tbl[10];

    always #5 clk = ~clk;

    rst_seq_ctrl #(.NUM_DOM(ND), .MIN_ASSERT(MIN), .REL_DLY(REL)) u_dut (
        .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .wdt_rst_req(wdt_rst_req),
        .dom_rst(dom_rst), .all_released(all_released), .busy(busy), .rst_cause(rst_cause)
    );

    rst_seq_ctrl #(.NUM_DOM(1), .MIN_ASSERT(1), .REL_DLY(1)) u_dut_min (
        .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .wdt_rst_req(wdt_rst_req),
        .dom_rst(dom_rst_m), .all_released(all_released_m), .busy(busy_m), .rst_cause(rst_cause_m)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    // Reference: every output follows from t, the number of clean edges since
    // the last reset or request edge.
    task automatic step();
        logic [ND-1:0] exp_dom;
        @(posedge clk);
        if (rst) begin
            t = 0;
            cause_exp = 2'b00;
        end else if (sw_rst_req || wdt_rst_req) begin
            t = 0;
            cause_exp = wdt_rst_req ? 2'b10 : 2'b01;
        end else if (t < 100000) begin
            t++;
        end
        #1;
        for (int i = 0; i < ND; i++) exp_dom[i] = (t < MIN + (i + 1) * REL);
        chk("model_dom_rst", 32'(dom_rst), 32'(exp_dom));
        chk("model_all_released", 32'(all_released), 32'(t >= MIN + ND * REL));
        chk("model_busy", 32'(busy), 32'(t < MIN + ND * REL));
        chk("model_rst_cause", 32'(rst_cause), 32'(cause_exp));
        chk("model_min_dom_rst", 32'(dom_rst_m), 32'(t < 2));
        chk("model_min_all_released", 32'(all_released_m), 32'(t >= 2));
        chk("model_min_rst_cause", 32'(rst_cause_m), 32'(cause_exp));
    endtask

    initial begin
        por_tbl[0] = '{1,  4'b1111, 1'b0, 1'b1};
        por_tbl[1] = '{23, 4'b1111, 1'b0, 1'b1};
        por_tbl[2] = '{24, 4'b1110, 1'b0, 1'b1};
        por_tbl[3] = '{39, 4'b1110, 1'b0, 1'b1};
        por_tbl[4] = '{40, 4'b1100, 1'b0, 1'b1};
        por_tbl[5] = '{55, 4'b1100, 1'b0, 1'b1};
        por_tbl[6] = '{56, 4'b1000, 1'b0, 1'b1};
        por_tbl[7] = '{71, 4'b1000, 1'b0, 1'b1};
        por_tbl[8] = '{72, 4'b0000, 1'b1, 1'b0};
        por_tbl[9] = '{80, 4'b0000, 1'b1, 1'b0};

        // POR
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("rst_dom_rst", 32'(dom_rst), 32'hF);
        chk("rst_all_released", 32'(all_released), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_cause", 32'(rst_cause), 32'h0);
        rst = 1'b0;
        for (int e = 1; e <= 80; e++) begin
            step();
            if (e == 1) chk("min_dom_edge1", 32'(dom_rst_m), 32'h1);
            if (e == 2) chk("min_dom_edge2", 32'(dom_rst_m), 32'h0);
            for (int v = 0; v < 10; v++) begin
                if (por_tbl[v].edge_n == e) begin
                    chk("por_dom_rst", 32'(dom_rst), 32'(por_tbl[v].dom));
                    chk("por_all_released", 32'(all_released), 32'(por_tbl[v].all_rel));
                    chk("por_busy", 32'(busy), 32'(por_tbl[v].bsy));
                    chk("por_cause", 32'(rst_cause), 32'h0);
                end
            end
        end

        // SW pulse in DONE
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        chk("sw_dom_rst", 32'(dom_rst), 32'hF);
        chk("sw_busy", 32'(busy), 32'h1);
        chk("sw_cause", 32'(rst_cause), 32'h1);
        for (int k = 1; k <= 72; k++) begin
            step();
            if (k == 23) chk("sw_bit0_held", 32'(dom_rst[0]), 32'h1);
            if (k == 24) chk("sw_bit0_rel", 32'(dom_rst[0]), 32'h0);
            if (k == 71) chk("sw_not_done", 32'(all_released), 32'h0);
            if (k == 72) chk("sw_done", 32'(all_released), 32'h1);
        end

        // WDT mid-stagger at edge 45
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int e = 1; e <= 44; e++) step();
        chk("wdt_pre_dom", 32'(dom_rst), 32'hC);
        wdt_rst_req = 1'b1;
        step();
        wdt_rst_req = 1'b0;
        chk("wdt_dom_rst", 32'(dom_rst), 32'hF);
        chk("wdt_cause", 32'(rst_cause), 32'h2);
        for (int e = 46; e <= 117; e++) begin
            step();
            if (e == 116) chk("wdt_not_done", 32'(all_released), 32'h0);
            if (e == 117) chk("wdt_done", 32'(dom_rst), 32'h0);
        end

        // Simultaneous SW+WDT in DONE
        sw_rst_req = 1'b1;
        wdt_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        wdt_rst_req = 1'b0;
        chk("both_cause", 32'(rst_cause), 32'h2);

        // Request on the edge where dom_rst[2] would release
        for (int n = 0; n < 100 && t != 55; n++) step();
        chk("rel_edge_reached", 32'(t), 32'd55);
        chk("rel_edge_pre_dom", 32'(dom_rst), 32'hC);
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        chk("rel_edge_dom", 32'(dom_rst), 32'hF);
        chk("rel_edge_cause", 32'(rst_cause), 32'h1);

        // Level-held request
        sw_rst_req = 1'b1;
        for (int n = 0; n < 30; n++) begin
            step();
            chk("level_dom_held", 32'(dom_rst), 32'hF);
        end
        sw_rst_req = 1'b0;
        for (int k = 1; k <= 72; k++) begin
            step();
            if (k == 23) chk("level_e23", 32'(dom_rst), 32'hF);
            if (k == 24) chk("level_e24", 32'(dom_rst), 32'hE);
            if (k == 40) chk("level_e40", 32'(dom_rst), 32'hC);
            if (k == 56) chk("level_e56", 32'(dom_rst), 32'h8);
            if (k == 72) chk("level_e72", 32'(all_released), 32'h1);
        end

        // rst mid-sequence with cause WDT
        wdt_rst_req = 1'b1;
        step();
        wdt_rst_req = 1'b0;
        for (int n = 0; n < 100 && t != 49; n++) step();
        chk("midrst_cause_before", 32'(rst_cause), 32'h2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_dom", 32'(dom_rst), 32'hF);
        chk("midrst_all", 32'(all_released), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h1);
        chk("midrst_cause", 32'(rst_cause), 32'h0);

        // Random requests and resets against the model
        for (int n = 0; n < 4000; n++) begin
            sw_rst_req  = ($urandom_range(0, 99) < 2);
            wdt_rst_req = ($urandom_range(0, 99) < 1);
            rst         = ($urandom_range(0, 999) < 2);
            if ($urandom_range(0, 9) == 0) sw_rst_req = ($urandom_range(0, 1) == 1) ? sw_rst_req : 1'b0;
            step();
        end
        rst = 1'b0;
        sw_rst_req = 1'b0;
        wdt_rst_req = 1'b0;
        for (int n = 0; n < 80; n++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
